// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, ALU/alu_src encodings, FSM state and control-bundle
// type for the ID-stage control unit.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_SLL  = 4'h2;
   localparam logic [3:0] ALU_SRL  = 4'h3;
   localparam logic [3:0] ALU_PASS = 4'h5;
   localparam logic [3:0] ALU_AND  = 4'h8;
   localparam logic [3:0] ALU_OR   = 4'h9;
   localparam logic [3:0] ALU_NOR  = 4'hD;

   localparam logic [1:0] SRC_RT    = 2'd0;
   localparam logic [1:0] SRC_IMM   = 2'd1;
   localparam logic [1:0] SRC_SHAMT = 2'd2;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   typedef struct packed {
      logic [1:0] alu_src;
      logic [3:0] alu_sel;
      logic       dst_sel;
      logic       wb_sel;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Purely combinational opcode/funct decode into a control bundle, with jump
// and illegal-encoding indications.
module pipe_ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       is_jump,
   output logic       illegal
);

   always_comb begin
      ctrl    = CTRL_NOP;
      is_jump = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.alu_src = SRC_RT;
            ctrl.wb_sel  = 1'b1;
            ctrl.reg_wr  = 1'b1;
            case (funct)
               FN_ADD: ctrl.alu_sel = ALU_ADD;
               FN_SUB: ctrl.alu_sel = ALU_SUB;
               FN_AND: ctrl.alu_sel = ALU_AND;
               FN_OR:  ctrl.alu_sel = ALU_OR;
               FN_NOR: ctrl.alu_sel = ALU_NOR;
               FN_SLL: begin
                  ctrl.alu_sel = ALU_SLL;
                  ctrl.alu_src = SRC_SHAMT;
               end
               FN_SRL: begin
                  ctrl.alu_sel = ALU_SRL;
                  ctrl.alu_src = SRC_SHAMT;
               end
               default: begin
                  ctrl    = CTRL_NOP;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            ctrl.alu_src = SRC_IMM;
            ctrl.dst_sel = 1'b1;
            ctrl.wb_sel  = 1'b1;
            ctrl.reg_wr  = 1'b1;
            ctrl.alu_sel = (opcode == OP_ADDI) ? ALU_ADD :
                           (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
         end
         OP_LW: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.alu_src = SRC_IMM;
            ctrl.dst_sel = 1'b1;
            ctrl.mem_rd  = 1'b1;
            ctrl.reg_wr  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.alu_src = SRC_IMM;
            ctrl.mem_wr  = 1'b1;
         end
         OP_J:    is_jump = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: registered control bundle, jump flush, sticky illegal flag
// and pipeline enables. Load-use stalling is built when PIPE_CTRL_HAZARD_EN is defined.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODE_W       = 6,
   parameter int REG_AW         = 5,
   parameter int ALU_SEL_W      = 4,
   parameter int JUMP_FLUSH_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [OPCODE_W-1:0]  funct,
   input  logic [REG_AW-1:0]    rs,
   input  logic [REG_AW-1:0]    rt,
   input  logic [REG_AW-1:0]    rd,
   output logic                 pc_enable,
   output logic                 sel_pc_jump,
   output logic                 if_id_enable,
   output logic                 if_id_flush,
   output logic                 id_exe_enable,
   output logic                 exe_mem_enable,
   output logic                 mem_wb_enable,
   output logic [1:0]           alu_src,
   output logic [ALU_SEL_W-1:0] alu_sel,
   output logic                 dst_sel,
   output logic                 wb_sel,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic                 reg_wr,
   output logic [REG_AW-1:0]    dst_reg,
   output logic                 illegal_op
);

   localparam logic [2:0] FLUSH_LOAD = 3'(JUMP_FLUSH_CYC - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [REG_AW-1:0]   dst_q, dst_d;
   logic                ill_q, ill_d;
   ctrl_t               dec_ctrl;
   logic                dec_jump, dec_illegal, hazard;
   logic                pc_en_c, ifid_en_c, jump_c, flush_c;

   pipe_ctrl_decode u_decode (
      .opcode  (opcode),
      .funct   (funct),
      .ctrl    (dec_ctrl),
      .is_jump (dec_jump),
      .illegal (dec_illegal)
   );

`ifdef PIPE_CTRL_HAZARD_EN
   logic              shd_ld_q;
   logic [REG_AW-1:0] shd_dst_q;
   logic              uses_rt;

   assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW);
   assign hazard  = instr_valid && shd_ld_q && (shd_dst_q != '0) &&
                    ((rs == shd_dst_q) || (uses_rt && (rt == shd_dst_q)));

   // Shadow follows whatever enters ID/EX, so a bubble clears the load flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd_ld_q  <= 1'b0;
         shd_dst_q <= '0;
      end else begin
         shd_ld_q  <= ctrl_d.mem_rd;
         shd_dst_q <= rt;
      end
   end
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^rs;
   assign hazard = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = CTRL_NOP;
      dst_d     = '0;
      ill_d     = ill_q;
      pc_en_c   = 1'b1;
      ifid_en_c = 1'b1;
      jump_c    = 1'b0;
      flush_c   = 1'b0;
      case (state_q)
         FLUSH: begin
            flush_c = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
         end
         default: begin
            // STALL decides like RUN: the cleared shadow flag cannot re-stall.
            state_d = RUN;
            if (hazard) begin
               pc_en_c   = 1'b0;
               ifid_en_c = 1'b0;
               state_d   = STALL;
            end else if (instr_valid && dec_jump) begin
               jump_c  = 1'b1;
               flush_c = 1'b1;
               cnt_d   = FLUSH_LOAD;
               if (FLUSH_LOAD != 3'd0) state_d = FLUSH;
            end else if (instr_valid) begin
               if (dec_illegal) begin
                  ill_d = 1'b1;
               end else begin
                  ctrl_d = dec_ctrl;
                  dst_d  = dec_ctrl.dst_sel ? rt : rd;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ctrl_q  <= CTRL_NOP;
         dst_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         dst_q   <= dst_d;
         ill_q   <= ill_d;
      end
   end

   assign pc_enable      = pc_en_c & ~rst;
   assign if_id_enable   = ifid_en_c & ~rst;
   assign sel_pc_jump    = jump_c & ~rst;
   assign if_id_flush    = flush_c & ~rst;
   assign id_exe_enable  = ~rst;
   assign exe_mem_enable = ~rst;
   assign mem_wb_enable  = ~rst;

   assign alu_src    = ctrl_q.alu_src;
   assign alu_sel    = ALU_SEL_W'(ctrl_q.alu_sel);
   assign dst_sel    = ctrl_q.dst_sel;
   assign wb_sel     = ctrl_q.wb_sel;
   assign mem_rd     = ctrl_q.mem_rd;
   assign mem_wr     = ctrl_q.mem_wr;
   assign reg_wr     = ctrl_q.reg_wr;
   assign dst_reg    = dst_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized
// instruction streams compared against a per-instruction behavioural model.
module tb_pipe_ctrl_unit;

   localparam int N = 3;

   logic       clk, rst, instr_valid;
   logic [5:0] opcode, funct;
   logic [4:0] rs, rt, rd;
   logic       pc_enable, sel_pc_jump, if_id_enable, if_id_flush;
   logic       id_exe_enable, exe_mem_enable, mem_wb_enable;
   logic [1:0] alu_src;
   logic [3:0] alu_sel;
   logic       dst_sel, wb_sel, mem_rd, mem_wr, reg_wr;
   logic [4:0] dst_reg;
   logic       illegal_op;

   int checks = 0;
   int errors = 0;

   // model state: last issued instruction, pending flush cycles, sticky flag
   bit          m_ld = 0;
   logic [4:0]  m_dst = '0;
   int          m_flush = 0;
   bit          m_ill = 0;
   logic [15:0] m_vec = '0;
   logic        obs_pc, obs_ifid, obs_jmp, obs_fl;

   logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h08, 6'h0C,
                               6'h0D, 6'h23, 6'h23, 6'h2B, 6'h3F, 6'h01};
   logic [5:0] fn_tab [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h15};

   pipe_ctrl_unit #(
      .OPCODE_W       (6),
      .REG_AW         (5),
      .ALU_SEL_W      (4),
      .JUMP_FLUSH_CYC (N)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_valid    (instr_valid),
      .opcode         (opcode),
      .funct          (funct),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .pc_enable      (pc_enable),
      .sel_pc_jump    (sel_pc_jump),
      .if_id_enable   (if_id_enable),
      .if_id_flush    (if_id_flush),
      .id_exe_enable  (id_exe_enable),
      .exe_mem_enable (exe_mem_enable),
      .mem_wb_enable  (mem_wb_enable),
      .alu_src        (alu_src),
      .alu_sel        (alu_sel),
      .dst_sel        (dst_sel),
      .wb_sel         (wb_sel),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .reg_wr         (reg_wr),
      .dst_reg        (dst_reg),
      .illegal_op     (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Instruction-set table: what each encoding means for the ID/EX bundle.
   function automatic void mdec(input logic [5:0] op, input logic [5:0] fn,
                                output bit ok, output bit jmp, output int src, output int sel,
                                output bit dsel, output bit wbs, output bit mrd,
                                output bit mwr, output bit rwr);
      ok = 1; jmp = 0; src = 0; sel = 0; dsel = 0; wbs = 0; mrd = 0; mwr = 0; rwr = 0;
      case (op)
         6'h00: begin
            wbs = 1; rwr = 1;
            case (fn)
               6'h20: sel = 0;
               6'h22: sel = 1;
               6'h24: sel = 8;
               6'h25: sel = 9;
               6'h27: sel = 13;
               6'h00: begin sel = 2; src = 2; end
               6'h02: begin sel = 3; src = 2; end
               default: begin ok = 0; wbs = 0; rwr = 0; end
            endcase
         end
         6'h08: begin src = 1; dsel = 1; wbs = 1; rwr = 1; sel = 0; end
         6'h0C: begin src = 1; dsel = 1; wbs = 1; rwr = 1; sel = 8; end
         6'h0D: begin src = 1; dsel = 1; wbs = 1; rwr = 1; sel = 9; end
         6'h23: begin src = 1; dsel = 1; mrd = 1; rwr = 1; end
         6'h2B: begin src = 1; mwr = 1; end
         6'h02: jmp = 1;
         default: ok = 0;
      endcase
   endfunction

   function automatic logic [23:0] all_outs();
      return {pc_enable, sel_pc_jump, if_id_enable, if_id_flush, id_exe_enable,
              exe_mem_enable, mem_wb_enable, alu_src, alu_sel, dst_sel, wb_sel,
              mem_rd, mem_wr, reg_wr, dst_reg, illegal_op};
   endfunction

   // Called at posedge+1: present one instruction, check combinational
   // outputs mid-cycle, then check the registered bundle after the edge.
   task automatic step(input bit v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      bit ok, jmp, dsel, wbs, mrd, mwr, rwr, haz, epc, eif, ej, efl, nld;
      int src, sel;
      logic [15:0] nvec;
      instr_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d;
      #2;
      mdec(op, fn, ok, jmp, src, sel, dsel, wbs, mrd, mwr, rwr);
      haz = 0;
`ifdef PIPE_CTRL_HAZARD_EN
      haz = v && m_ld && (m_dst != 5'd0) &&
            ((s == m_dst) || (((op == 6'h00) || (op == 6'h2B)) && (t == m_dst)));
`endif
      nvec = '0;
      nld  = 0;
      if (m_flush > 0) begin
         epc = 1; eif = 1; ej = 0; efl = 1;
         m_flush--;
      end else if (haz) begin
         epc = 0; eif = 0; ej = 0; efl = 0;
      end else begin
         epc = 1; eif = 1; ej = v && jmp; efl = ej;
         if (ej) m_flush = N - 1;
         else if (v && ok) begin
            nvec = {2'(src), 4'(sel), dsel, wbs, mrd, mwr, rwr, (dsel ? t : d)};
            nld  = mrd;
         end else if (v) m_ill = 1;
      end
      obs_pc = pc_enable; obs_ifid = if_id_enable; obs_jmp = sel_pc_jump; obs_fl = if_id_flush;
      chk("comb_enables", {pc_enable, sel_pc_jump, if_id_enable, if_id_flush}, {epc, ej, eif, efl});
      chk("stage_enables", {id_exe_enable, exe_mem_enable, mem_wb_enable}, 3'b111);
      @(posedge clk);
      #1;
      m_vec = nvec;
      m_ld  = nld;
      m_dst = t;
      chk("bundle", {alu_src, alu_sel, dst_sel, wb_sel, mem_rd, mem_wr, reg_wr, dst_reg}, m_vec);
      chk("illegal_op", illegal_op, m_ill);
   endtask

   initial begin
      int fl_cnt, jmp_cnt, bub_cnt;
      rst = 1'b1; instr_valid = 0; opcode = '0; funct = '0; rs = '0; rt = '0; rd = '0;
      #2;
      chk("reset_outputs", all_outs(), 24'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // add r3 <- r1 + r2
      step(1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
      chk("add_alu_sel", alu_sel, 4'h0);
      chk("add_alu_src", alu_src, 2'd0);
      chk("add_wb_regwr", {wb_sel, reg_wr}, 2'b11);
      chk("add_dst_reg", dst_reg, 5'd3);

      // jump with three IF/ID bubbles; valid adds offered behind it
      fl_cnt = 0; jmp_cnt = 0; bub_cnt = 0;
      step(1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
      fl_cnt += int'(obs_fl); jmp_cnt += int'(obs_jmp); bub_cnt += int'(!reg_wr);
      for (int i = 0; i < 3; i++) begin
         step(1, 6'h00, 6'h25, 5'd1, 5'd2, 5'd7);
         fl_cnt += int'(obs_fl); jmp_cnt += int'(obs_jmp);
         if (i < 2) bub_cnt += int'(!reg_wr);
      end
      chk("jump_flush_cycles", fl_cnt, 3);
      chk("jump_pc_sel_cycles", jmp_cnt, 1);
      chk("jump_bubbles", bub_cnt, 3);
      chk("post_jump_or", {reg_wr, alu_sel, dst_reg}, {1'b1, 4'h9, 5'd7});

      // load-use: lw r5 then add using r5
      step(1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
      step(1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd4);
`ifdef PIPE_CTRL_HAZARD_EN
      chk("loaduse_stall", {obs_pc, obs_ifid, reg_wr}, 3'b000);
      step(1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd4);
      chk("loaduse_issue", {obs_pc, reg_wr, dst_reg}, {1'b1, 1'b1, 5'd4});
`else
      chk("loaduse_nostall", {obs_pc, obs_ifid, reg_wr}, 3'b111);
`endif
      // lw to r0 never stalls
      step(1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0);
      step(1, 6'h00, 6'h20, 5'd0, 5'd2, 5'd4);
      chk("lw_r0_nostall", {obs_pc, obs_ifid}, 2'b11);

      // reset in the middle of a flush
      step(1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
      instr_valid = 0;
      #1 rst = 1'b1;
      #1 chk("rst_mid_flush", all_outs(), 24'h0);
      #2 rst = 1'b0;
      m_ld = 0; m_dst = '0; m_flush = 0; m_ill = 0; m_vec = '0;
      @(posedge clk);
      #1;
      chk("post_rst_enables", {pc_enable, if_id_enable, id_exe_enable, exe_mem_enable, mem_wb_enable, if_id_flush}, 6'b111110);
      chk("post_rst_illegal", illegal_op, 1'b0);

      // illegal opcode then ori
      step(1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
      chk("illegal_set", {illegal_op, reg_wr, mem_rd, mem_wr}, 4'b1000);
      step(1, 6'h0D, 6'h00, 5'd1, 5'd6, 5'd3);
      chk("ori_after_illegal", {alu_sel, alu_src, dst_reg, illegal_op}, {4'h9, 2'd1, 5'd6, 1'b1});

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 8, op_tab[$urandom_range(0, 11)], fn_tab[$urandom_range(0, 7)],
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation decode/control block for the 5-stage MIPS-subset pipeline.
- Decodes the ID-stage instruction (opcode plus funct) into a registered control bundle that drives the ID/EX register.
- Adds load-use hazard stalling, jump flushing with a programmable bubble count, and illegal-opcode flagging.
- Generates the per-stage pipeline enables and the PC enable.

Parameters:
- OPCODE_W, 6, opcode and funct field width.
- REG_AW, 5, register-address width.
- ALU_SEL_W, 4, ALU select width.
- JUMP_FLUSH_CYC, 1, number of IF/ID bubbles inserted after a taken jump (1..7).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  the ID-stage instruction is valid.
- opcode  in  OPCODE_W  instruction bits [31:26].
- funct  in  OPCODE_W  instruction bits [5:0].
- rs  in  REG_AW  source register 1.
- rt  in  REG_AW  source register 2 / I-type destination.
- rd  in  REG_AW  R-type destination.
- pc_enable  out  1  PC register load enable.
- sel_pc_jump  out  1  PC mux selects the jump target.
- if_id_enable  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_exe_enable, exe_mem_enable, mem_wb_enable  out  1 each  stage register enables.
- alu_src  out  2  ALU B-input select: 0 = rt, 1 = sign-extended immediate, 2 = shamt.
- alu_sel  out  ALU_SEL_W  ALU operation select.
- dst_sel  out  1  destination select: 0 = rd, 1 = rt.
- wb_sel  out  1  write-back source: 0 = memory, 1 = ALU.
- mem_rd, mem_wr, reg_wr  out  1 each  active-high strobes.
- dst_reg  out  REG_AW  resolved destination register, registered with the bundle.
- illegal_op  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (asynchronous):
  - Every output is 0.
  - State is RUN; the flush counter is 0; the shadow load register is cleared.
- Decode, with ALU codes add 0, sub 1, sll 2, srl 3, pass 5, and 8, or 9, nor D:
  - R-type (opcode 0x00), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, sll 0x00, srl 0x02.
  - R-type strobes: alu_src 0 (2 for shifts), dst_sel 0, wb_sel 1, reg_wr 1.
  - addi 0x08, andi 0x0C, ori 0x0D: alu_src 1, dst_sel 1, wb_sel 1, reg_wr 1.
  - lw 0x23: alu add, alu_src 1, dst_sel 1, wb_sel 0, mem_rd 1, reg_wr 1.
  - sw 0x2B: alu add, alu_src 1, mem_wr 1, reg_wr 0.
  - j 0x02: no bundle strobes; triggers the jump flush.
- Bundle latency and bubbles:
  - The control bundle and dst_reg are registered; latency is 1 cycle, aligned with ID/EX.
  - A bubble is an all-zero bundle. It is issued when instr_valid = 0, in STALL, in FLUSH, or on an illegal opcode.
- Hazard tracking:
  - A shadow register holds the destination (rt) and a load flag of the bundle last issued.
  - Hazard condition: shadow load flag = 1, shadow dst != 0, and (rs == dst, or rt == dst for R-type and sw).
- Enables: pc_enable, if_id_enable, sel_pc_jump and if_id_flush are combinational from state and current inputs (0-cycle latency). id_exe_enable, exe_mem_enable and mem_wb_enable are 1 outside reset.
- FSM states and transitions:
  - RUN:
    - Hazard → pc_enable 0, if_id_enable 0, issue a bubble, go to STALL.
    - Else, valid j → sel_pc_jump 1, if_id_flush 1, issue a bubble, load the counter with JUMP_FLUSH_CYC-1. Go to FLUSH if the loaded value is nonzero, else stay in RUN.
    - Else → normal issue, all enables 1.
  - STALL: lasts exactly 1 cycle. The shadow load flag was cleared by the bubble, so the held instruction issues normally on return to RUN.
  - FLUSH: if_id_flush 1, bubble issued; the counter decrements each cycle; leave for RUN when the counter reaches 0.
- Boundary conditions:
  - Hazard and j together: the hazard wins; the jump is re-evaluated after the stall.
  - rst mid-STALL or mid-FLUSH: immediate return to RUN with the bundle zeroed.
- illegal_op:
  - Set on a valid, undecoded opcode/funct.
  - Cleared only by rst.
  - The illegal instruction issues as a bubble.

Optional Feature:
- Macro: PIPE_CTRL_HAZARD_EN.
- Defined: load-use detection and the STALL state as above.
- Undefined: no hazard logic or STALL state; the hazard term is constant 0; software must schedule a NOP after every lw. Jump flush is unaffected.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU select codes;
  - alu_src encodings;
  - the FSM state enum (RUN, STALL, FLUSH);
  - the control-bundle struct typedef.
- One sub-module, pipe_ctrl_decode: purely combinational opcode/funct → bundle plus illegal flag. The FSM, counter, shadow register and output registers stay in the top.

Test Plan:
- rst high mid-FLUSH → all outputs 0 asynchronously; after release, enables 1 and illegal_op 0.
- add (op 0x00, funct 0x20, rd 3) → next cycle alu_sel 0, alu_src 0, wb_sel 1, reg_wr 1, dst_reg 3.
- lw rt=5 followed by add rs=5 → one cycle of pc_enable=0, if_id_enable=0 and a bubble; the add then issues; with HAZARD_EN undefined, no stall occurs.
- lw rt=0 followed by add rs=0 → no stall.
- j with JUMP_FLUSH_CYC=3 → sel_pc_jump pulses 1 cycle; if_id_flush is high 3 cycles; 3 bubbles issue; then RUN.
- opcode 0x3F valid → illegal_op=1 and a bubble issues; the following valid ori still decodes with alu_sel 9 and alu_src 1; illegal_op stays 1.
